// File: rtl/sram_arb_ctrl_if.sv
// Bundle of both requester ports plus the SRAM macro pins seen by sram_arb_ctrl.
// The slave modport is the arbiter's view; master is the requesters'/macro side.
interface sram_arb_ctrl_if #(
  parameter int unsigned BITS       = 8,
  parameter int unsigned ADDR_WIDTH = 13
);
  // Port 0 (AHB slave datapath)
  logic                  p0_valid;
  logic                  p0_ready;
  logic                  p0_we;
  logic [ADDR_WIDTH-1:0] p0_addr;
  logic [BITS-1:0]       p0_wdata;
  logic                  p0_lock;
  logic                  p0_rvalid;
  logic [BITS-1:0]       p0_rdata;
  // Port 1 (secondary master)
  logic                  p1_valid;
  logic                  p1_ready;
  logic                  p1_we;
  logic [ADDR_WIDTH-1:0] p1_addr;
  logic [BITS-1:0]       p1_wdata;
  logic                  p1_lock;
  logic                  p1_rvalid;
  logic [BITS-1:0]       p1_rdata;
  // SRAM macro pins
  logic                  CEN;
  logic                  WEN;
  logic [ADDR_WIDTH-1:0] A;
  logic [BITS-1:0]       D;
  logic                  OEN;
  logic [BITS-1:0]       Q;

  modport slave (
    input  p0_valid, p0_we, p0_addr, p0_wdata, p0_lock,
    output p0_ready, p0_rvalid, p0_rdata,
    input  p1_valid, p1_we, p1_addr, p1_wdata, p1_lock,
    output p1_ready, p1_rvalid, p1_rdata,
    output CEN, WEN, A, D, OEN,
    input  Q
  );

  modport master (
    output p0_valid, p0_we, p0_addr, p0_wdata, p0_lock,
    input  p0_ready, p0_rvalid, p0_rdata,
    output p1_valid, p1_we, p1_addr, p1_wdata, p1_lock,
    input  p1_ready, p1_rvalid, p1_rdata,
    input  CEN, WEN, A, D, OEN,
    output Q
  );
endinterface

// File: rtl/sram_arb_ctrl.sv
// Two-port arbiter/sequencer for a single-port negedge-sampled SRAM macro.
// One access is granted per cycle (round-robin or fixed priority, with a bounded
// lock); macro pins are driven from registers and read data returns one cycle
// after acceptance as a single-cycle valid pulse to the owning port.
module sram_arb_ctrl #(
  parameter int unsigned BITS       = 8,
  parameter int unsigned ADDR_WIDTH = 13,
  parameter bit          FIXED_PRIO = 1'b0,
  parameter int unsigned LOCK_MAX   = 4
) (
  input logic            CLK,
  input logic            RST,
  sram_arb_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(LOCK_MAX + 1);

  logic                  cen_q, wen_q;
  logic [ADDR_WIDTH-1:0] a_q;
  logic [BITS-1:0]       d_q;
  logic [1:0]            rvalid_q;
  logic [BITS-1:0]       rdata0_q, rdata1_q;
  logic                  last_grant_q;
  logic                  lock_active_q, lock_port_q;
  logic [CntW-1:0]       lock_cnt_q;
  logic                  rd_pend_q, rd_port_q;

  logic [1:0]            valid;
  logic                  lock_valid, other_valid, cnt_ok;
  logic                  gnt_any, gnt;
  logic                  sel_we, sel_lock;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [BITS-1:0]       sel_wdata;

  // Grant select: honoured lock, then single requester, then tie-break.
  always_comb begin
    valid       = {bus.p1_valid, bus.p0_valid};
    lock_valid  = valid[lock_port_q];
    other_valid = valid[~lock_port_q];
    cnt_ok      = lock_cnt_q < CntW'(LOCK_MAX);
    gnt_any     = 1'b0;
    gnt         = 1'b0;
    if (lock_active_q && lock_valid && (cnt_ok || !other_valid)) begin
      gnt_any = 1'b1;
      gnt     = lock_port_q;
    end else if (valid == 2'b01) begin
      gnt_any = 1'b1;
      gnt     = 1'b0;
    end else if (valid == 2'b10) begin
      gnt_any = 1'b1;
      gnt     = 1'b1;
    end else if (valid == 2'b11) begin
      gnt_any = 1'b1;
      if (lock_active_q && lock_valid) begin
        // Lock exhausted with the other port waiting: hand over.
        gnt = ~lock_port_q;
      end else if (FIXED_PRIO) begin
        gnt = 1'b0;
      end else begin
        gnt = ~last_grant_q;
      end
    end
    if (RST) begin
      gnt_any = 1'b0;
    end
    sel_we    = gnt ? bus.p1_we    : bus.p0_we;
    sel_lock  = gnt ? bus.p1_lock  : bus.p0_lock;
    sel_addr  = gnt ? bus.p1_addr  : bus.p0_addr;
    sel_wdata = gnt ? bus.p1_wdata : bus.p0_wdata;
  end

  assign bus.p0_ready  = gnt_any & ~gnt;
  assign bus.p1_ready  = gnt_any & gnt;
  assign bus.CEN       = cen_q;
  assign bus.WEN       = wen_q;
  assign bus.A         = a_q;
  assign bus.D         = d_q;
  assign bus.OEN       = 1'b0;
  assign bus.p0_rvalid = rvalid_q[0];
  assign bus.p1_rvalid = rvalid_q[1];
  assign bus.p0_rdata  = rdata0_q;
  assign bus.p1_rdata  = rdata1_q;

  // Macro pin sequencing, lock bookkeeping and read-data return.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cen_q         <= 1'b1;
      wen_q         <= 1'b1;
      a_q           <= '0;
      d_q           <= '0;
      rvalid_q      <= 2'b00;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      last_grant_q  <= 1'b1;
      lock_active_q <= 1'b0;
      lock_port_q   <= 1'b0;
      lock_cnt_q    <= '0;
      rd_pend_q     <= 1'b0;
      rd_port_q     <= 1'b0;
    end else begin
      if (gnt_any) begin
        cen_q        <= 1'b0;
        wen_q        <= ~sel_we;
        a_q          <= sel_addr;
        d_q          <= sel_wdata;
        last_grant_q <= gnt;
        rd_pend_q    <= ~sel_we;
        rd_port_q    <= gnt;
        if (sel_lock) begin
          lock_active_q <= 1'b1;
          lock_port_q   <= gnt;
          if (lock_active_q && (gnt == lock_port_q)) begin
            if (cnt_ok) begin
              lock_cnt_q <= lock_cnt_q + CntW'(1);
            end
          end else begin
            lock_cnt_q <= CntW'(1);
          end
        end else begin
          lock_active_q <= 1'b0;
          lock_cnt_q    <= '0;
        end
      end else begin
        cen_q     <= 1'b1;
        wen_q     <= 1'b1;
        rd_pend_q <= 1'b0;
        if (lock_active_q && !lock_valid) begin
          lock_active_q <= 1'b0;
          lock_cnt_q    <= '0;
        end
      end
      // Q is valid here because the macro sampled on the preceding negedge.
      rvalid_q <= 2'b00;
      if (rd_pend_q) begin
        rvalid_q[rd_port_q] <= 1'b1;
        if (rd_port_q) begin
          rdata1_q <= bus.Q;
        end else begin
          rdata0_q <= bus.Q;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Bench for sram_arb_ctrl: vector table with expected grants, a reference memory,
// and queues of expected pin states and read returns checked on the negedge.
module tb_sram_arb_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  always #5 CLK = ~CLK;

  sram_arb_ctrl_if #(.BITS(8), .ADDR_WIDTH(13)) ifa ();
  sram_arb_ctrl_if #(.BITS(8), .ADDR_WIDTH(13)) ifb ();

  sram_arb_ctrl #(.BITS(8), .ADDR_WIDTH(13), .FIXED_PRIO(1'b0), .LOCK_MAX(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (ifa.slave)
  );

  sram_arb_ctrl #(.BITS(8), .ADDR_WIDTH(13), .FIXED_PRIO(1'b1), .LOCK_MAX(4)) dut_fp (
    .CLK (CLK),
    .RST (RST),
    .bus (ifb.slave)
  );

  function automatic logic [7:0] pat(input logic [12:0] a);
    return a[7:0] ^ {3'b000, a[12:8]} ^ 8'h5A;
  endfunction

  // Behavioural SRAM macros, sampled on the falling edge.
  logic [7:0] mem_a [0:8191];
  logic [7:0] ref_mem [0:8191];

  always @(negedge CLK) begin
    if (ifa.CEN === 1'b0) begin
      if (ifa.WEN === 1'b0) mem_a[ifa.A] <= ifa.D;
      else                  ifa.Q <= mem_a[ifa.A];
    end
  end

  always @(negedge CLK) begin
    if (ifb.CEN === 1'b0 && ifb.WEN === 1'b1) ifb.Q <= pat(ifb.A);
  end

  typedef struct {
    logic        rst;
    logic        v0, we0, lk0;
    logic [12:0] a0;
    logic [7:0]  d0;
    logic        v1, we1, lk1;
    logic [12:0] a1;
    logic [7:0]  d1;
    logic        er0, er1;
  } vec_t;

  typedef struct {
    int          due;
    logic        cen, wen;
    logic [12:0] a;
    logic [7:0]  d;
  } pin_t;

  typedef struct {
    int         due;
    logic       port;
    logic [7:0] data;
  } rd_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  pin_t pin_q[$];
  rd_t  rd_q[$];
  vec_t tbl[$];
  logic [12:0] exp_a = '0;
  logic [7:0]  exp_d = '0;

  function automatic vec_t mk(input logic rst,
                              input logic v0, input logic we0, input logic [12:0] a0,
                              input logic [7:0] d0, input logic lk0,
                              input logic v1, input logic we1, input logic [12:0] a1,
                              input logic [7:0] d1, input logic lk1,
                              input logic er0, input logic er1);
    vec_t v;
    v.rst = rst;
    v.v0 = v0; v.we0 = we0; v.a0 = a0; v.d0 = d0; v.lk0 = lk0;
    v.v1 = v1; v.we1 = we1; v.a1 = a1; v.d1 = d1; v.lk1 = lk1;
    v.er0 = er0; v.er1 = er1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // One cycle on the main DUT: drive, check on the negedge, queue expectations.
  task automatic step(input vec_t v);
    pin_t pe;
    rd_t  re;
    logic        gp, gwe;
    logic [12:0] ga;
    logic [7:0]  gd;
    RST = v.rst;
    ifa.p0_valid = v.v0; ifa.p0_we = v.we0; ifa.p0_addr = v.a0;
    ifa.p0_wdata = v.d0; ifa.p0_lock = v.lk0;
    ifa.p1_valid = v.v1; ifa.p1_we = v.we1; ifa.p1_addr = v.a1;
    ifa.p1_wdata = v.d1; ifa.p1_lock = v.lk1;
    @(negedge CLK);
    cyc++;
    if (pin_q.size() > 0) begin
      if (pin_q[0].due == cyc) begin
        pe = pin_q.pop_front();
        chk("pins{CEN,WEN,A,D}", {9'd0, ifa.CEN, ifa.WEN, ifa.A, ifa.D},
            {9'd0, pe.cen, pe.wen, pe.a, pe.d});
      end
    end
    re.due = -1;
    if (rd_q.size() > 0) begin
      if (rd_q[0].due == cyc) re = rd_q.pop_front();
    end
    if (re.due == cyc) begin
      if (re.port) begin
        chk("p1_rvalid", {31'd0, ifa.p1_rvalid}, 32'd1);
        chk("p1_rdata", {24'd0, ifa.p1_rdata}, {24'd0, re.data});
        chk("p0_rvalid_quiet", {31'd0, ifa.p0_rvalid}, 32'd0);
      end else begin
        chk("p0_rvalid", {31'd0, ifa.p0_rvalid}, 32'd1);
        chk("p0_rdata", {24'd0, ifa.p0_rdata}, {24'd0, re.data});
        chk("p1_rvalid_quiet", {31'd0, ifa.p1_rvalid}, 32'd0);
      end
    end else begin
      chk("rvalid_idle", {30'd0, ifa.p1_rvalid, ifa.p0_rvalid}, 32'd0);
    end
    chk("ready{p1,p0}", {30'd0, ifa.p1_ready, ifa.p0_ready}, {30'd0, v.er1, v.er0});
    if (v.rst) begin
      exp_a = '0;
      exp_d = '0;
      pin_q.push_back('{cyc + 1, 1'b1, 1'b1, 13'd0, 8'd0});
      rd_q.delete();
    end else if (v.er0 || v.er1) begin
      gp  = v.er1;
      gwe = gp ? v.we1 : v.we0;
      ga  = gp ? v.a1 : v.a0;
      gd  = gp ? v.d1 : v.d0;
      exp_a = ga;
      exp_d = gd;
      pin_q.push_back('{cyc + 1, 1'b0, ~gwe, ga, gd});
      if (gwe) ref_mem[ga] = gd;
      else     rd_q.push_back('{cyc + 2, gp, ref_mem[ga]});
    end else begin
      pin_q.push_back('{cyc + 1, 1'b1, 1'b1, exp_a, exp_d});
    end
    @(posedge CLK);
    #1;
  endtask

  vec_t idle;
  int   n0, n1;

  initial begin
    for (int i = 0; i < 8192; i++) begin
      mem_a[i]   = pat(13'(i));
      ref_mem[i] = pat(13'(i));
    end
    ifa.Q = '0;
    ifb.Q = '0;
    ifb.p0_valid = 1'b0; ifb.p0_we = 1'b0; ifb.p0_addr = '0; ifb.p0_wdata = '0;
    ifb.p0_lock = 1'b0;
    ifb.p1_valid = 1'b0; ifb.p1_we = 1'b0; ifb.p1_addr = '0; ifb.p1_wdata = '0;
    ifb.p1_lock = 1'b0;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //              rst v0 we0 a0       d0     lk v1 we1 a1       d1 lk er0 er1
    tbl.push_back(mk(1, 0, 0, 13'h0000, 8'h00, 0, 0, 0, 13'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 13'h0000, 8'h00, 0, 0, 0, 13'h0000, 0, 0, 0, 0));
    // Port 0 write then read-back
    tbl.push_back(mk(0, 1, 1, 13'h0010, 8'hA5, 0, 0, 0, 13'h0000, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 13'h0010, 8'h00, 0, 0, 0, 13'h0000, 0, 0, 1, 0));
    tbl.push_back(idle);
    tbl.push_back(idle);
    // Round-robin between continuous readers (last grant was port 0)
    tbl.push_back(mk(0, 1, 0, 13'h0100, 8'h00, 0, 1, 0, 13'h0200, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 13'h0100, 8'h00, 0, 1, 0, 13'h0201, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 13'h0101, 8'h00, 0, 1, 0, 13'h0201, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 13'h0101, 8'h00, 0, 1, 0, 13'h0202, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 13'h0102, 8'h00, 0, 1, 0, 13'h0202, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 13'h0102, 8'h00, 0, 0, 0, 13'h0000, 0, 0, 1, 0));
    // Port 1 locked burst of 6 against a waiting port 0, LOCK_MAX = 4
    tbl.push_back(mk(0, 1, 0, 13'h0300, 8'h00, 0, 1, 0, 13'h0400, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 13'h0300, 8'h00, 0, 1, 0, 13'h0401, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 13'h0300, 8'h00, 0, 1, 0, 13'h0402, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 13'h0300, 8'h00, 0, 1, 0, 13'h0403, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 13'h0300, 8'h00, 0, 1, 0, 13'h0404, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 13'h0301, 8'h00, 0, 1, 0, 13'h0404, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 13'h0301, 8'h00, 0, 1, 0, 13'h0405, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 13'h0301, 8'h00, 0, 0, 0, 13'h0000, 0, 0, 1, 0));
    tbl.push_back(idle);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i]);
      if (i == 1) begin
        chk("reset_p0_rdata", {24'd0, ifa.p0_rdata}, 32'd0);
        chk("reset_p1_rdata", {24'd0, ifa.p1_rdata}, 32'd0);
        chk("reset_OEN", {31'd0, ifa.OEN}, 32'd0);
      end
    end

    // Write to the top address, then immediate read-back
    step(mk(0, 1, 1, 13'h1FFF, 8'h3C, 0, 0, 0, 13'h0000, 0, 0, 1, 0));
    step(mk(0, 1, 0, 13'h1FFF, 8'h00, 0, 0, 0, 13'h0000, 0, 0, 1, 0));
    step(idle);
    step(idle);
    // Same read-after-write through port 1
    step(mk(0, 0, 0, 13'h0000, 8'h00, 0, 1, 1, 13'h0020, 8'h77, 0, 0, 1));
    step(mk(0, 0, 0, 13'h0000, 8'h00, 0, 1, 0, 13'h0020, 8'h00, 0, 0, 1));
    step(idle);
    step(idle);

    // Read accepted, then reset on the next edge: the return must be dropped
    step(mk(0, 1, 0, 13'h0005, 8'h00, 0, 0, 0, 13'h0000, 0, 0, 1, 0));
    step(mk(1, 0, 0, 13'h0000, 8'h00, 0, 0, 0, 13'h0000, 0, 0, 0, 0));
    // First tie after reset goes to port 0
    step(mk(0, 1, 0, 13'h0006, 8'h00, 0, 1, 0, 13'h0007, 0, 0, 1, 0));
    step(mk(0, 0, 0, 13'h0000, 8'h00, 0, 1, 0, 13'h0007, 0, 0, 0, 1));
    step(idle);
    step(idle);
    step(idle);

    // Fixed-priority instance: port 0 wins every cycle, port 1 starves
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 9; i++) begin
      ifb.p0_valid = (i < 6); ifb.p0_we = 1'b0; ifb.p0_addr = 13'(13'h0040 + i);
      ifb.p1_valid = (i < 6); ifb.p1_we = 1'b0; ifb.p1_addr = 13'h0080;
      @(negedge CLK);
      if (i < 6) begin
        chk("fp_ready{p1,p0}", {30'd0, ifb.p1_ready, ifb.p0_ready}, 32'd1);
      end
      if (ifb.p0_rvalid === 1'b1) begin
        chk("fp_p0_rdata", {24'd0, ifb.p0_rdata}, {24'd0, pat(13'(13'h0040 + n0))});
        n0++;
      end
      if (ifb.p1_rvalid === 1'b1) n1++;
      @(posedge CLK);
      #1;
    end
    chk("fp_p0_rvalid_count", n0, 32'd6);
    chk("fp_p1_rvalid_count", n1, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
